// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the phase sequencer:
//   - seq_state_t : sequencer state encoding (IDLE, RUN, HALTED)
//   - PH_FETCH / PH_DECODE : fixed phase-pointer indices
//   - op_slot_of() : maps a phase pointer to the op slot it belongs to
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;

    // Slot k owns pointers 2+2k (SELECT) and 3+2k (EXEC); all other
    // pointers (FETCH, DECODE, PAD, RETIRE) report slot 0.
    function automatic int unsigned op_slot_of(input int unsigned p,
                                               input int unsigned max_ops);
        if (p >= 2 && p < 2 + 2 * max_ops)
            return (p - 2) / 2;
        else
            return 0;
    endfunction

endpackage

// File: rtl/phase_next.sv
// -----------------------------------------------------------------------------
// phase_next
// Combinational next-phase-pointer function for phase_sequencer.
// Ports:
//   p       in  PW     current phase pointer
//   op_cnt  in  OPE_W  clamped op count that applies to this edge
//   stall   in  1      hold the pointer when high
//   p_next  out PW     pointer after the next clk edge (RUN state only)
// COMPACT=0 walks every pointer; COMPACT=1 jumps over unused slots and PAD.
// -----------------------------------------------------------------------------
module phase_next
    import cpu_pkg::*;
#(
    parameter int NUM_PHASES = 12,
    parameter int MAX_OPS    = 3,
    parameter int OPE_W      = 4,
    parameter int COMPACT    = 0,
    parameter int PW         = $clog2(NUM_PHASES)
) (
    input  logic [PW-1:0]    p,
    input  logic [OPE_W-1:0] op_cnt,
    input  logic             stall,
    output logic [PW-1:0]    p_next
);

    localparam logic [PW-1:0] P_RETIRE = PW'(NUM_PHASES - 1);

    int unsigned p_int;
    int unsigned slot_k;

    always_comb begin
        p_int  = 32'(p);
        slot_k = 0;
        p_next = p;
        if (!stall) begin
            if (p == P_RETIRE) begin
                p_next = PW'(PH_FETCH);
            end else if (COMPACT == 0) begin
                p_next = p + PW'(1);
            end else if (p_int == PH_DECODE) begin
                p_next = (op_cnt != '0) ? PW'(2) : P_RETIRE;
            end else if (p_int >= 3 && p_int <= 2 * MAX_OPS + 1 && p_int[0]) begin
                // EXEC of slot k: continue only while more ops remain
                slot_k = (p_int - 3) / 2;
                p_next = (slot_k + 1 < 32'(op_cnt)) ? p + PW'(1) : P_RETIRE;
            end else begin
                p_next = p + PW'(1);
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
// One-hot phase generator driving fetch/decode/select/exec/retire strobes.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   num_of_ope   in   op count from decode, latched on the DECODE edge
//   stall        in   holds the current phase
//   halt_req     in   sampled at RETIRE, moves to HALTED
//   phase        out  one-hot phase vector (all zero in IDLE/HALTED)
//   op_idx       out  active op slot index, 0 outside slots
//   op_cnt       out  latched op count, clamped to MAX_OPS
//   retire       out  phase[NUM_PHASES-1]
//   halted       out  high in HALTED
//   ope_err      out  sticky: num_of_ope > MAX_OPS was latched
//   cycle_count  out  RUN-cycle counter
//   instr_count  out  retired-instruction counter
// Optional: define PHASE_SEQ_PERF_EN to build the two perf counters;
// otherwise they read constant 0.
// -----------------------------------------------------------------------------
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_PHASES = 12,
    parameter int MAX_OPS    = 3,
    parameter int OPE_W      = 4,
    parameter int COMPACT    = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [OPE_W-1:0]               num_of_ope,
    input  logic                           stall,
    input  logic                           halt_req,
    output logic [NUM_PHASES-1:0]          phase,
    output logic [$clog2(MAX_OPS+1)-1:0]   op_idx,
    output logic [OPE_W-1:0]               op_cnt,
    output logic                           retire,
    output logic                           halted,
    output logic                           ope_err,
    output logic [31:0]                    cycle_count,
    output logic [31:0]                    instr_count
);

    localparam int PW = $clog2(NUM_PHASES);
    localparam int IW = $clog2(MAX_OPS + 1);

    seq_state_t            state_reg;
    logic [PW-1:0]         p_reg;
    logic [NUM_PHASES-1:0] phase_reg;
    logic [IW-1:0]         op_idx_reg;
    logic [OPE_W-1:0]      op_cnt_reg;
    logic                  halted_reg;
    logic                  ope_err_reg;

    logic [PW-1:0]         p_next;
    logic [NUM_PHASES-1:0] phase_dec;
    logic [IW-1:0]         op_idx_next;
    logic                  at_decode;
    logic                  at_retire;
    logic                  ope_over;
    logic [OPE_W-1:0]      op_cnt_clamped;
    logic [OPE_W-1:0]      op_cnt_eff;

    assign at_decode      = (p_reg == PW'(PH_DECODE));
    assign at_retire      = (p_reg == PW'(NUM_PHASES - 1));
    assign ope_over       = (32'(num_of_ope) > MAX_OPS);
    assign op_cnt_clamped = ope_over ? OPE_W'(MAX_OPS) : num_of_ope;
    // The DECODE edge must branch on the count being latched, not the old one.
    assign op_cnt_eff     = at_decode ? op_cnt_clamped : op_cnt_reg;

    phase_next #(
        .NUM_PHASES (NUM_PHASES),
        .MAX_OPS    (MAX_OPS),
        .OPE_W      (OPE_W),
        .COMPACT    (COMPACT),
        .PW         (PW)
    ) u_phase_next (
        .p      (p_reg),
        .op_cnt (op_cnt_eff),
        .stall  (stall),
        .p_next (p_next)
    );

    // One-hot decode of the next pointer so phase is a plain register.
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase_dec
        assign phase_dec[gi] = (p_next == PW'(gi));
    end

    assign op_idx_next = IW'(op_slot_of(32'(p_next), MAX_OPS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            p_reg       <= '0;
            phase_reg   <= '0;
            op_idx_reg  <= '0;
            op_cnt_reg  <= '0;
            halted_reg  <= 1'b0;
            ope_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg  <= RUN;
                    p_reg      <= PW'(PH_FETCH);
                    phase_reg  <= NUM_PHASES'(1) << PH_FETCH;
                    op_idx_reg <= '0;
                end
                RUN: begin
                    if (at_retire && !stall && halt_req) begin
                        state_reg  <= HALTED;
                        phase_reg  <= '0;
                        op_idx_reg <= '0;
                        halted_reg <= 1'b1;
                    end else begin
                        p_reg      <= p_next;
                        phase_reg  <= phase_dec;
                        op_idx_reg <= op_idx_next;
                        if (at_decode && !stall) begin
                            op_cnt_reg <= op_cnt_clamped;
                            if (ope_over)
                                ope_err_reg <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    // only reset leaves HALTED
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign phase   = phase_reg;
    assign op_idx  = op_idx_reg;
    assign op_cnt  = op_cnt_reg;
    assign retire  = phase_reg[NUM_PHASES-1];
    assign halted  = halted_reg;
    assign ope_err = ope_err_reg;

`ifdef PHASE_SEQ_PERF_EN
    logic [31:0] cycle_count_reg;
    logic [31:0] instr_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count_reg <= '0;
            instr_count_reg <= '0;
        end else if (state_reg == RUN) begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
            if (at_retire && !stall)
                instr_count_reg <= instr_count_reg + 32'd1;
        end
    end

    assign cycle_count = cycle_count_reg;
    assign instr_count = instr_count_reg;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
// Directed bench for phase_sequencer: one legacy instance (COMPACT=0) and one
// compact instance (COMPACT=1). Counter expectations follow PHASE_SEQ_PERF_EN.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // legacy instance
    logic        reset_a = 1'b0;
    logic [3:0]  num_a   = 4'd2;
    logic        stall_a = 1'b0;
    logic        halt_a  = 1'b0;
    logic [11:0] phase_a;
    logic [1:0]  op_idx_a;
    logic [3:0]  op_cnt_a;
    logic        retire_a, halted_a, ope_err_a;
    logic [31:0] cyc_a, ins_a;

    // compact instance
    logic        reset_c = 1'b0;
    logic [3:0]  num_c   = 4'd1;
    logic        stall_c = 1'b0;
    logic        halt_c  = 1'b0;
    logic [11:0] phase_c;
    logic [1:0]  op_idx_c;
    logic [3:0]  op_cnt_c;
    logic        retire_c, halted_c, ope_err_c;
    logic [31:0] cyc_c, ins_c;

    phase_sequencer #(.NUM_PHASES(12), .MAX_OPS(3), .OPE_W(4), .COMPACT(0)) dut (
        .clk(clk), .reset(reset_a), .num_of_ope(num_a), .stall(stall_a),
        .halt_req(halt_a), .phase(phase_a), .op_idx(op_idx_a), .op_cnt(op_cnt_a),
        .retire(retire_a), .halted(halted_a), .ope_err(ope_err_a),
        .cycle_count(cyc_a), .instr_count(ins_a)
    );

    phase_sequencer #(.NUM_PHASES(12), .MAX_OPS(3), .OPE_W(4), .COMPACT(1)) dut_c (
        .clk(clk), .reset(reset_c), .num_of_ope(num_c), .stall(stall_c),
        .halt_req(halt_c), .phase(phase_c), .op_idx(op_idx_c), .op_cnt(op_cnt_c),
        .retire(retire_c), .halted(halted_c), .ope_err(ope_err_c),
        .cycle_count(cyc_c), .instr_count(ins_c)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected perf counter value: real count with counters built, else 0.
    function automatic logic [31:0] pexp(input int v);
`ifdef PHASE_SEQ_PERF_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    int unsigned idx_a [12] = '{0, 0, 0, 0, 1, 1, 2, 2, 0, 0, 0, 0};

    logic [11:0] c1_ph [5] = '{12'h002, 12'h004, 12'h008, 12'h800, 12'h001};
    logic [11:0] c0_ph [3] = '{12'h002, 12'h800, 12'h001};
    logic [11:0] c3_ph [9] = '{12'h002, 12'h004, 12'h008, 12'h010, 12'h020,
                               12'h040, 12'h080, 12'h800, 12'h001};
    int unsigned c3_ix [9] = '{0, 0, 0, 1, 1, 2, 2, 0, 0};

    initial begin
        logic [11:0] e;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_phase",   phase_a,   12'h000);
        check("rst_op_idx",  op_idx_a,  2'd0);
        check("rst_op_cnt",  op_cnt_a,  4'd0);
        check("rst_halted",  halted_a,  1'b0);
        check("rst_ope_err", ope_err_a, 1'b0);
        check("rst_retire",  retire_a,  1'b0);
        check("rst_cycles",  cyc_a,     32'd0);
        check("rst_instrs",  ins_a,     32'd0);

        // ---------------- legacy walk, num_of_ope=2 ----------------
        reset_a = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            step();
            e = 12'h001 << (i % 12);
            check($sformatf("walk_phase[%0d]", i), phase_a, e);
            check($sformatf("walk_idx[%0d]", i), op_idx_a, idx_a[i % 12]);
            check($sformatf("walk_retire[%0d]", i), retire_a, (i % 12) == 11);
            if (i == 2)
                check("walk_op_cnt", op_cnt_a, 4'd2);
        end

        // ---------------- clamp and sticky error ----------------
        num_a = 4'd7;
        step();
        step();
        check("clamp_op_cnt",  op_cnt_a,  4'd3);
        check("clamp_ope_err", ope_err_a, 1'b1);
        for (int i = 0; i < 10; i++) step();
        check("clamp_wrap_phase", phase_a, 12'h001);
        num_a = 4'd1;
        step();
        step();
        check("after_op_cnt",  op_cnt_a,  4'd1);
        check("sticky_ope_err", ope_err_a, 1'b1);

        // ---------------- stall at phase 0x010 ----------------
        step();
        step();
        check("pre_stall_phase",  phase_a, 12'h010);
        check("pre_stall_cycles", cyc_a,   pexp(28));
        check("pre_stall_instrs", ins_a,   pexp(2));
        stall_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("stall_phase[%0d]", i), phase_a, 12'h010);
            check($sformatf("stall_idx[%0d]", i), op_idx_a, 2'd1);
        end
        stall_a = 1'b0;
        step();
        check("post_stall_phase",  phase_a, 12'h020);
        check("post_stall_cycles", cyc_a,   pexp(33));
        check("post_stall_instrs", ins_a,   pexp(2));

        // ---------------- halt with stall priority ----------------
        for (int i = 0; i < 6; i++) step();
        check("retire_reached", retire_a, 1'b1);
        stall_a = 1'b1;
        halt_a  = 1'b1;
        step();
        check("halt_stall_phase0",  phase_a,  12'h800);
        check("halt_stall_halted0", halted_a, 1'b0);
        step();
        check("halt_stall_phase1",  phase_a,  12'h800);
        stall_a = 1'b0;
        step();
        check("halt_phase",  phase_a,  12'h000);
        check("halt_halted", halted_a, 1'b1);
        check("halt_retire", retire_a, 1'b0);
        check("halt_instrs", ins_a,    pexp(3));
        check("halt_cycles", cyc_a,    pexp(42));
        halt_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stall_a = (i == 1);
            step();
            check($sformatf("halted_phase[%0d]", i), phase_a, 12'h000);
            check($sformatf("halted_flag[%0d]", i), halted_a, 1'b1);
        end
        check("halted_cycles", cyc_a, pexp(42));
        stall_a = 1'b0;

        // ---------------- asynchronous reset mid-op ----------------
        reset_a = 1'b0;
        #1;
        check("rst_from_halt_halted", halted_a, 1'b0);
        reset_a = 1'b1;
        num_a   = 4'd2;
        step();
        check("restart_phase", phase_a, 12'h001);
        for (int i = 0; i < 6; i++) step();
        check("midop_phase",  phase_a,  12'h040);
        check("midop_op_cnt", op_cnt_a, 4'd2);
        check("midop_op_idx", op_idx_a, 2'd2);
        reset_a = 1'b0;
        #1;
        check("async_phase",   phase_a,   12'h000);
        check("async_op_cnt",  op_cnt_a,  4'd0);
        check("async_op_idx",  op_idx_a,  2'd0);
        check("async_ope_err", ope_err_a, 1'b0);
        step();
        check("held_rst_phase", phase_a, 12'h000);
        reset_a = 1'b1;
        step();
        check("rerelease_phase", phase_a, 12'h001);

        // ---------------- compact mode ----------------
        num_c   = 4'd1;
        reset_c = 1'b1;
        step();
        check("c_start_phase", phase_c, 12'h001);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("c1_phase[%0d]", i), phase_c, c1_ph[i]);
            check($sformatf("c1_idx[%0d]", i), op_idx_c, 2'd0);
            if (i == 1)
                check("c1_op_cnt", op_cnt_c, 4'd1);
        end
        num_c = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("c0_phase[%0d]", i), phase_c, c0_ph[i]);
        end
        check("c0_op_cnt", op_cnt_c, 4'd0);
        num_c = 4'd3;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("c3_phase[%0d]", i), phase_c, c3_ph[i]);
            check($sformatf("c3_idx[%0d]", i), op_idx_c, c3_ix[i]);
        end
        check("c3_op_cnt",  op_cnt_c,  4'd3);
        check("c3_ope_err", ope_err_c, 1'b0);
        check("c_instrs",   ins_c,     pexp(3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
